// File: rtl/branch_predictor_unit.sv
// Branch direction (2-bit PHT) and target (tagged direct-mapped BTB) predictor ahead of fetch.
// Optional gshare indexing enabled by defining BP_GSHARE_EN.
module branch_predictor_unit #(
  parameter int unsigned PHT_IDX_W = 8,
  parameter int unsigned BTB_IDX_W = 6,
  parameter int unsigned BTB_TAG_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bp_pc_i,
  output logic [36:0] bp_to_if_bus,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_state,
  output logic        init_done
);

  localparam int unsigned PhtN   = 1 << PHT_IDX_W;
  localparam int unsigned BtbN   = 1 << BTB_IDX_W;
  localparam int unsigned TagLsb = BTB_IDX_W + 2;
  localparam int unsigned TagMsb = BTB_TAG_W + BTB_IDX_W + 1;

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e               state;
  logic [PHT_IDX_W-1:0] cnt;

  logic [1:0]           pht        [PhtN];
  logic [BtbN-1:0]      btb_valid;
  logic [BTB_TAG_W-1:0] btb_tag    [BtbN];
  logic [31:0]          btb_target [BtbN];

  logic [PHT_IDX_W-1:0] lk_pidx, up_pidx;
  logic [BTB_IDX_W-1:0] lk_bidx, up_bidx;
  logic [BTB_TAG_W-1:0] lk_tag, up_tag;
  logic [1:0]           lk_state, up_cnt;
  logic                 lk_hit;

  assign lk_bidx = bp_pc_i[BTB_IDX_W+1:2];
  assign up_bidx = upd_pc[BTB_IDX_W+1:2];
  assign lk_tag  = bp_pc_i[TagMsb:TagLsb];
  assign up_tag  = upd_pc[TagMsb:TagLsb];

`ifdef BP_GSHARE_EN
  logic [PHT_IDX_W-1:0] ghr;
  assign lk_pidx = bp_pc_i[PHT_IDX_W+1:2] ^ ghr;
  assign up_pidx = upd_pc[PHT_IDX_W+1:2] ^ ghr;
`else
  assign lk_pidx = bp_pc_i[PHT_IDX_W+1:2];
  assign up_pidx = upd_pc[PHT_IDX_W+1:2];
`endif

  // New counter derives from the state carried with the branch, not a table re-read.
  always_comb begin
    up_cnt = upd_state;
    if (upd_taken && upd_state != 2'b11) begin
      up_cnt = upd_state + 2'b01;
    end else if (!upd_taken && upd_state != 2'b00) begin
      up_cnt = upd_state - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StInit;
      cnt       <= '0;
      init_done <= 1'b0;
`ifdef BP_GSHARE_EN
      ghr       <= '0;
`endif
    end else begin
      case (state)
        StInit: begin
          pht[cnt] <= 2'b01;
          if ({{(32 - PHT_IDX_W){1'b0}}, cnt} < BtbN) begin
            btb_valid[cnt[BTB_IDX_W-1:0]] <= 1'b0;
          end
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state     <= StReady;
            init_done <= 1'b1;
          end
        end
        StReady: begin
          if (upd_valid) begin
            pht[up_pidx] <= up_cnt;
            if (upd_taken) begin
              btb_valid[up_bidx]  <= 1'b1;
              btb_tag[up_bidx]    <= up_tag;
              btb_target[up_bidx] <= upd_target;
            end
`ifdef BP_GSHARE_EN
            ghr <= {ghr[PHT_IDX_W-2:0], upd_taken};
`endif
          end
        end
        default: state <= StInit;
      endcase
    end
  end

  // Lookup sees pre-update table contents; no same-cycle bypass.
  always_comb begin
    lk_state     = pht[lk_pidx];
    lk_hit       = btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);
    bp_to_if_bus = '0;
    if (state == StReady) begin
      bp_to_if_bus = {1'b1, lk_state[1], lk_state, lk_hit,
                      lk_hit ? btb_target[lk_bidx] : 32'h0};
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp_pc_i[1:0], upd_pc[1:0], bp_pc_i[31:TagMsb+1], upd_pc[31:TagMsb+1]};

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed self-checking bench for branch_predictor_unit.
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] bp_pc_i;
  logic [36:0] bp_to_if_bus;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_state;
  logic        init_done;

  int errors = 0;
  int checks = 0;

  branch_predictor_unit dut (
    .clk          (clk),
    .reset        (reset),
    .bp_pc_i      (bp_pc_i),
    .bp_to_if_bus (bp_to_if_bus),
    .upd_valid    (upd_valid),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_state    (upd_state),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic [1:0] st);
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    upd_state  = st;
    upd_valid  = 1'b1;
    tick();
    upd_valid  = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic [36:0] exp);
    bp_pc_i = pc;
    #1;
    checks++;
    if (bp_to_if_bus !== exp) begin
      errors++;
      $display("FAIL %s pc=%h got=%h want=%h", name, pc, bp_to_if_bus, exp);
    end
  endtask

  task automatic wait_init(input string name);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (bp_to_if_bus !== 37'h0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL %s cycle=%0d bus=%h init_done=%b want 0/0", name, i, bp_to_if_bus,
                 init_done);
      end
      tick();
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done got=%b want=1", name, init_done);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    upd_valid = 1'b0;
    bp_pc_i   = 32'h1c000000;
    tick();
    tick();
    reset = 1'b0;
    wait_init("init_hold");
    look("ready_default", 32'h1c000000, {1'b1, 1'b0, 2'b01, 1'b0, 32'h0});
  endtask

`ifndef BP_GSHARE_EN
  task automatic test_train();
    do_update(32'h1c000010, 1'b1, 32'h1c000100, 2'b01);
    do_update(32'h1c000010, 1'b1, 32'h1c000100, 2'b10);
    do_update(32'h1c000010, 1'b1, 32'h1c000100, 2'b11);
    look("train_hit", 32'h1c000010, {1'b1, 1'b1, 2'b11, 1'b1, 32'h1c000100});
    do_update(32'h1c000010, 1'b1, 32'h1c000100, 2'b11);
    look("sat_high", 32'h1c000010, {1'b1, 1'b1, 2'b11, 1'b1, 32'h1c000100});
    look("pc_low_bits", 32'h1c000013, {1'b1, 1'b1, 2'b11, 1'b1, 32'h1c000100});
  endtask

  task automatic test_not_taken();
    // Not-taken leaves the BTB entry in place.
    do_update(32'h1c000010, 1'b0, 32'hdeadbeef, 2'b11);
    look("dec_from_11", 32'h1c000010, {1'b1, 1'b1, 2'b10, 1'b1, 32'h1c000100});
    do_update(32'h1c000010, 1'b0, 32'hdeadbeef, 2'b00);
    look("sat_low", 32'h1c000010, {1'b1, 1'b0, 2'b00, 1'b1, 32'h1c000100});
  endtask

  task automatic test_alias();
    look("alias_btb_miss", 32'h1c000410, {1'b1, 1'b0, 2'b00, 1'b0, 32'h0});
    look("alias_pht_wrap", 32'h1c000810, {1'b1, 1'b0, 2'b00, 1'b0, 32'h0});
    look("neighbor_clean", 32'h1c000014, {1'b1, 1'b0, 2'b01, 1'b0, 32'h0});
  endtask

  task automatic test_same_cycle();
    bp_pc_i    = 32'h1c000020;
    upd_pc     = 32'h1c000020;
    upd_taken  = 1'b1;
    upd_target = 32'h1c000200;
    upd_state  = 2'b01;
    upd_valid  = 1'b1;
    look("same_cycle_pre", 32'h1c000020, {1'b1, 1'b0, 2'b01, 1'b0, 32'h0});
    tick();
    upd_valid = 1'b0;
    look("same_cycle_post", 32'h1c000020, {1'b1, 1'b1, 2'b10, 1'b1, 32'h1c000200});
  endtask

  task automatic test_back_to_back();
    do_update(32'h1c000030, 1'b1, 32'h1c000300, 2'b01);
    do_update(32'h1c000034, 1'b0, 32'h1c000340, 2'b01);
    look("b2b_taken", 32'h1c000030, {1'b1, 1'b1, 2'b10, 1'b1, 32'h1c000300});
    look("b2b_not_taken", 32'h1c000034, {1'b1, 1'b0, 2'b00, 1'b0, 32'h0});
  endtask
`endif

  task automatic test_init_reset();
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    upd_pc     = 32'h1c000040;
    upd_taken  = 1'b1;
    upd_target = 32'h1c000400;
    upd_state  = 2'b11;
    upd_valid  = 1'b1;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i == 200) upd_valid = 1'b0;
      checks++;
      if (init_done !== 1'b0) begin
        errors++;
        $display("FAIL reinit_hold cycle=%0d init_done=%b want=0", i, init_done);
      end
      tick();
    end
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL reinit_done got=%b want=1", init_done);
    end
    look("init_upd_ignored", 32'h1c000040, {1'b1, 1'b0, 2'b01, 1'b0, 32'h0});
    look("reinit_cleared", 32'h1c000010, {1'b1, 1'b0, 2'b01, 1'b0, 32'h0});
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    // idx 3^0=3 -> 11, ghr=1; then idx 1^1=0 -> 10, ghr=3.
    do_update(32'h1c00000c, 1'b1, 32'h1c0000c0, 2'b10);
    do_update(32'h1c000004, 1'b1, 32'h1c000040, 2'b01);
    look("gshare_idx3", 32'h1c000000, {1'b1, 1'b1, 2'b11, 1'b0, 32'h0});
    look("gshare_idx0", 32'h1c00000c, {1'b1, 1'b1, 2'b10, 1'b1, 32'h1c0000c0});
  endtask
`endif

  initial begin
    upd_valid  = 1'b0;
    upd_pc     = '0;
    upd_taken  = 1'b0;
    upd_target = '0;
    upd_state  = '0;
    test_reset();
`ifndef BP_GSHARE_EN
    test_train();
    test_not_taken();
    test_alias();
    test_same_cycle();
    test_back_to_back();
`endif
    test_init_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_unit.md
Name: branch_predictor_unit

Overview:
Branch direction and target predictor that sits directly upstream of the fetch stage. It is looked up combinationally with the current fetch PC and returns the packed prediction bus that fetch uses to select its next PC. It holds a pattern history table (PHT) of 2-bit saturating counters and a direct-mapped, tagged branch target buffer (BTB). It is trained by a resolve-time update port driven from the execute stage.

Parameters:
PHT_IDX_W, 8, PHT index width; PHT has 2^PHT_IDX_W entries.
BTB_IDX_W, 6, BTB index width; BTB has 2^BTB_IDX_W entries.
BTB_TAG_W, 20, BTB tag width, taken from PC bits above the BTB index.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bp_pc_i  in  32  fetch PC to predict for
bp_to_if_bus  out  37  packed {predict_valid[36], predict_taken[35], predict_state[34:33], btb_hit[32], predict_target[31:0]}
upd_valid  in  1  update strobe, one resolved branch per cycle
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  actual direction
upd_target  in  32  actual target
upd_state  in  2  predict_state carried down the pipe with this branch
init_done  out  1  high once table clearing has completed

Behaviour:
- Reset: FSM enters INIT and the clear counter is set to 0. init_done=0 and every bus field is 0.
- INIT:
  - Each cycle writes PHT[cnt]=2'b01 (weakly not-taken) and clears BTB valid[cnt] when cnt < 2^BTB_IDX_W.
  - Then cnt+1. When cnt reaches 2^PHT_IDX_W-1, the state moves to READY on the next edge.
  - The clear takes exactly 2^PHT_IDX_W cycles, so init_done rises 256 cycles after reset deasserts (defaults).
- READY: init_done=1 and predict_valid=1.
- Reset asserted mid-operation (any state) returns to INIT with cnt=0 and restarts the clear.
- Lookup is purely combinational from bp_pc_i (zero latency):
  - pidx=bp_pc_i[PHT_IDX_W+1:2].
  - bidx=bp_pc_i[BTB_IDX_W+1:2].
  - tag=bp_pc_i[BTB_TAG_W+BTB_IDX_W+1:BTB_IDX_W+2].
  - predict_state=PHT[pidx].
  - predict_taken=predict_state[1].
  - btb_hit=BTB valid[bidx] && tag match.
  - predict_target=BTB target[bidx] when btb_hit, else 0.
  - In INIT, predict_valid=0, predict_taken=0, btb_hit=0 and predict_target=0.
- Update, registered and applied at the clock edge when upd_valid && READY:
  - PHT[pidx(upd_pc)] is set to the saturating value of upd_state: +1 if upd_taken, −1 if not.
  - Saturation: 11 stays 11 on taken; 00 stays 00 on not-taken.
  - The counter is computed from upd_state, not from a re-read of the table.
  - If upd_taken: BTB[bidx(upd_pc)] is written with valid=1, the upd_pc tag and upd_target. This allocates or overwrites; there is no replacement policy beyond direct mapping.
  - If not taken: the BTB is left unchanged.
- upd_valid during INIT is ignored and does not disturb the clear.
- Lookup and update to the same index in one cycle: the lookup returns the pre-update value. There is no bypass; the new value is visible the following cycle.
- PC bits [1:0] are ignored everywhere.
- Index wrap: PC values differing only above the index bits alias to the same PHT/BTB entry. The BTB tag disambiguates; the PHT does not.

Optional Feature:
BP_GSHARE_EN:
- Defined:
  - A PHT_IDX_W-bit global history register (GHR), reset to 0 and held at 0 during INIT.
  - On each READY update, the GHR shifts left by one with upd_taken inserted at bit 0.
  - PHT lookup index = bp_pc_i[PHT_IDX_W+1:2] XOR GHR.
  - PHT update index = upd_pc[PHT_IDX_W+1:2] XOR the GHR value before the shift.
- Undefined: no GHR; the PHT is indexed by PC bits only, as above.
- The BTB is unaffected either way.

Test Plan:
- Reset, hold 300 cycles, sample bp_to_if_bus with bp_pc_i=0x1c000000 -> bus=0 for the first 256 cycles after reset release. init_done rises at cycle 256. Then predict_valid=1, state=01, taken=0, btb_hit=0.
- After init, three updates to upd_pc=0x1c000010 with upd_taken=1, upd_target=0x1c000100, upd_state following 01→10→11 -> lookup of 0x1c000010 gives state=11, taken=1, btb_hit=1, target=0x1c000100. A fourth update with upd_state=11, taken=1 keeps 11.
- Alias check with upd_pc=0x1c000010 then lookup of 0x1c000410 (same BTB index, different tag) -> btb_hit=0; PHT aliasing per index width.
- Same-cycle lookup and update at PC 0x1c000020 (taken, upd_state=01) -> that cycle shows state=01, btb_hit=0; the next cycle shows 10, btb_hit=1.
- upd_valid pulses during INIT, then assert reset at cycle 100 of INIT -> the clear restarts and init_done rises 256 cycles after the second reset release. No entry reflects the INIT-time updates.
- With BP_GSHARE_EN: after taken updates, GHR=0x03. A lookup of PC 0x1c000000 reads PHT[0x03] -> state matches the value written at that xored index.
